uc_irq: RTL and testbench

UC_IRQ -- requirements
Module: uc_irq

---
 rtl/uc_irq.sv | 152 +++++++++++++++
 tb/tb_uc_irq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uc_irq.sv
// Control unit for the small CPU core: instruction decode plus edge-triggered,
// fixed-priority, non-nesting interrupt entry/return sequencing.
module uc_irq #(
  parameter int N_IRQ = 2,
  parameter int IDX_W = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             z,
  input  logic [N_IRQ-1:0] irq,
  output logic             s_inc,
  output logic             we3,
  output logic             wez,
  output logic             pop,
  output logic             push,
  output logic             s_stack,
  output logic             we4,
  output logic             we_out,
  output logic             timer_e,
  output logic             s_mem,
  output logic [1:0]       s_inm,
  output logic [1:0]       s_in,
  output logic [1:0]       s_out,
  output logic [2:0]       op_alu,
  output logic             s_vec,
  output logic             s_ret_cur,
  output logic [IDX_W-1:0] vec_idx,
  output logic [N_IRQ-1:0] irq_ack,
  output logic             in_isr,
  output logic             ie
);

  typedef enum logic {RUN = 1'b0, ISR = 1'b1} state_t;

  localparam logic [5:0] OP_EI   = 6'b110001;
  localparam logic [5:0] OP_DI   = 6'b110010;
  localparam logic [5:0] OP_RETI = 6'b110011;

  state_t             state, state_n;
  logic               ie_n;
  logic               primed;
  logic [N_IRQ-1:0]   irq_prev, pending, pending_n, rise, sel_onehot;
  logic [IDX_W-1:0]   sel_idx;
  logic               entry;

  // primed stays low for the first cycle after reset so a line already high
  // at release is treated as old news, not as a fresh edge.
  assign rise  = irq & ~irq_prev & {N_IRQ{primed}};
  assign entry = (state == RUN) && ie && (|pending);
  assign in_isr = (state == ISR);

  // Fixed priority: scanning downward leaves the lowest set index selected.
  always_comb begin
    sel_idx    = '0;
    sel_onehot = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel_idx       = IDX_W'(i);
        sel_onehot    = '0;
        sel_onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      ie       <= 1'b0;
      pending  <= '0;
      irq_prev <= '0;
      primed   <= 1'b0;
    end else begin
      state    <= state_n;
      ie       <= ie_n;
      pending  <= pending_n;
      irq_prev <= irq;
      primed   <= 1'b1;
    end
  end

  // Next state: an entry slot swallows the fetched opcode, so EI/DI/RETI in
  // that slot have no effect.
  always_comb begin
    state_n   = state;
    ie_n      = ie;
    pending_n = (pending & ~(entry ? sel_onehot : '0)) | rise;
    if (entry) begin
      state_n = ISR;
      ie_n    = 1'b0;
    end else begin
      case (opcode)
        OP_EI:   ie_n = 1'b1;
        OP_DI:   ie_n = 1'b0;
        OP_RETI: begin
          ie_n    = 1'b1;
          state_n = RUN;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    s_inc     = 1'b1;
    we3       = 1'b0;
    wez       = 1'b0;
    pop       = 1'b0;
    push      = 1'b0;
    s_stack   = 1'b0;
    we4       = 1'b0;
    we_out    = 1'b0;
    timer_e   = 1'b0;
    s_mem     = 1'b0;
    s_inm     = 2'b00;
    s_in      = 2'b00;
    s_out     = 2'b00;
    op_alu    = 3'b000;
    s_vec     = 1'b0;
    s_ret_cur = 1'b0;
    vec_idx   = '0;
    irq_ack   = '0;
    if (entry) begin
      s_inc     = 1'b0;
      push      = 1'b1;
      s_ret_cur = 1'b1;
      s_vec     = 1'b1;
      vec_idx   = sel_idx;
      irq_ack   = sel_onehot;
    end else begin
      casez (opcode)
        6'b0?????: begin we3 = 1'b1; wez = 1'b1; op_alu = opcode[4:2]; end
        6'b1000??: begin we3 = 1'b1; s_inm = 2'b01; end
        6'b100100: s_inc = 1'b0;
        6'b100101: s_inc = ~z;
        6'b100110: s_inc = z;
        6'b101000,
        6'b110011: begin s_inc = 1'b0; pop = 1'b1; s_stack = 1'b1; end
        6'b101001: push = 1'b1;
        6'b101010: begin we3 = 1'b1; s_inm = 2'b11; s_in = opcode[1:0]; end
        6'b101011: begin we_out = 1'b1; s_out = 2'b00; end
        6'b101100: begin we_out = 1'b1; s_out = 2'b01; end
        6'b1110??: we4 = 1'b1;
        6'b110000: begin we4 = 1'b1; s_mem = 1'b1; end
        6'b1111??: begin we3 = 1'b1; s_inm = 2'b10; end
        6'b101111: timer_e = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uc_irq.sv
// Bench for uc_irq: decode table, hand-written interrupt sequences, and a
// randomized run checked every cycle against a behavioural model.
module tb_uc_irq;

  typedef struct packed {
    logic       s_inc, we3, wez, pop, push, s_stack, we4, we_out, timer_e, s_mem;
    logic [1:0] s_inm, s_in, s_out;
    logic [2:0] op_alu;
    logic       s_vec, s_ret_cur;
    logic [0:0] vec_idx;
    logic [1:0] irq_ack;
    logic       in_isr, ie;
  } ctl_t;

  typedef struct {
    logic [5:0] op;
    logic       z;
    ctl_t       want;
  } vec_t;

  localparam logic [5:0] NOP  = 6'b110111;
  localparam logic [5:0] EI   = 6'b110001;
  localparam logic [5:0] RETI = 6'b110011;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode = NOP;
  logic       z = 1'b0;
  logic [1:0] irq = 2'b00;

  logic s_inc, we3, wez, pop, push, s_stack, we4, we_out, timer_e, s_mem;
  logic [1:0] s_inm, s_in, s_out, irq_ack;
  logic [2:0] op_alu;
  logic s_vec, s_ret_cur, in_isr, ie;
  logic [0:0] vec_idx;
  ctl_t got, cur;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  bit       m_ie, m_isr, m_armed;
  bit [1:0] m_pend, m_prev;

  vec_t tbl[$];

  always #5 clk = ~clk;

  uc_irq dut (
    .clk(clk), .reset(reset), .opcode(opcode), .z(z), .irq(irq),
    .s_inc(s_inc), .we3(we3), .wez(wez), .pop(pop), .push(push),
    .s_stack(s_stack), .we4(we4), .we_out(we_out), .timer_e(timer_e),
    .s_mem(s_mem), .s_inm(s_inm), .s_in(s_in), .s_out(s_out),
    .op_alu(op_alu), .s_vec(s_vec), .s_ret_cur(s_ret_cur),
    .vec_idx(vec_idx), .irq_ack(irq_ack), .in_isr(in_isr), .ie(ie)
  );

  assign got = '{s_inc, we3, wez, pop, push, s_stack, we4, we_out, timer_e, s_mem,
                 s_inm, s_in, s_out, op_alu, s_vec, s_ret_cur, vec_idx, irq_ack,
                 in_isr, ie};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic ctl_t nop_ctl();
    ctl_t c;
    c = '0;
    c.s_inc = 1'b1;
    return c;
  endfunction

  // Expected outputs straight from the decode rules.
  function automatic ctl_t model_out(logic [5:0] op, logic zz, bit mie, bit misr, bit [1:0] pend);
    ctl_t c;
    int   v;
    c = nop_ctl();
    c.in_isr = misr;
    c.ie = mie;
    v = int'(op);
    if (!misr && mie && pend != 2'b00) begin
      c.s_inc = 1'b0; c.push = 1'b1; c.s_ret_cur = 1'b1; c.s_vec = 1'b1;
      if (pend[0]) begin c.vec_idx = 1'b0; c.irq_ack = 2'b01; end
      else begin c.vec_idx = 1'b1; c.irq_ack = 2'b10; end
      return c;
    end
    if (v < 32) begin c.we3 = 1; c.wez = 1; c.op_alu = 3'((v / 4) % 8); end
    else if (v <= 35) begin c.we3 = 1; c.s_inm = 2'b01; end
    else if (v >= 56 && v <= 59) c.we4 = 1;
    else if (v >= 60) begin c.we3 = 1; c.s_inm = 2'b10; end
    else begin
      case (v)
        36: c.s_inc = 0;
        37: c.s_inc = !zz;
        38: c.s_inc = zz;
        40, 51: begin c.s_inc = 0; c.pop = 1; c.s_stack = 1; end
        41: c.push = 1;
        42: begin c.we3 = 1; c.s_inm = 2'b11; c.s_in = 2'b10; end
        43: begin c.we_out = 1; c.s_out = 2'b00; end
        44: begin c.we_out = 1; c.s_out = 2'b01; end
        47: c.timer_e = 1;
        48: begin c.we4 = 1; c.s_mem = 1; end
        default: ;
      endcase
    end
    return c;
  endfunction

  // Advance the model across one clock edge using the inputs now being driven.
  task automatic model_edge();
    bit       entry;
    bit [1:0] r;
    entry = !m_isr && m_ie && m_pend != 2'b00;
    r = m_armed ? (irq & ~m_prev) : 2'b00;
    if (entry) begin
      m_pend = m_pend[0] ? (m_pend & 2'b10) : 2'b00;
      m_ie = 0;
      m_isr = 1;
    end else if (opcode == EI) m_ie = 1;
    else if (opcode == 6'b110010) m_ie = 0;
    else if (opcode == RETI) begin m_ie = 1; m_isr = 0; end
    m_pend = m_pend | r;
    m_prev = irq;
    m_armed = 1;
  endtask

  task automatic step(input logic [5:0] op, input logic zz, input logic [1:0] ir);
    @(posedge clk);
    #2;
    opcode = op; z = zz; irq = ir;
    #5;
    cur = got;
    check("model", 32'(cur), 32'(model_out(op, zz, m_ie, m_isr, m_pend)));
    model_edge();
  endtask

  // Asserts reset asynchronously mid-cycle, checks the held outputs, releases.
  task automatic do_reset(input logic [1:0] ir);
    ctl_t w;
    #3;
    reset = 1'b0;
    opcode = 6'b010100; z = 1'b0; irq = ir;
    #1;
    w = nop_ctl(); w.we3 = 1; w.wez = 1; w.op_alu = 3'b101;
    check("reset_out", 32'(got), 32'(w));
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    opcode = NOP;
    m_ie = 0; m_isr = 0; m_pend = 0; m_prev = 0; m_armed = 0;
    model_edge();
  endtask

  task automatic add(input logic [5:0] op, input logic zz, input ctl_t w);
    vec_t v;
    v.op = op; v.z = zz; v.want = w;
    tbl.push_back(v);
  endtask

  initial begin
    ctl_t e;

    e = nop_ctl(); e.we3 = 1; e.wez = 1; e.op_alu = 3'b101; add(6'b010100, 0, e);
    e = nop_ctl(); e.we3 = 1; e.wez = 1; e.op_alu = 3'b111; add(6'b011111, 1, e);
    e = nop_ctl(); e.we3 = 1; e.s_inm = 2'b01; add(6'b100010, 0, e);
    e = nop_ctl(); e.s_inc = 0; add(6'b100100, 0, e);
    e = nop_ctl(); e.s_inc = 0; add(6'b100101, 1, e);
    e = nop_ctl(); add(6'b100101, 0, e);
    e = nop_ctl(); e.s_inc = 0; add(6'b100110, 0, e);
    e = nop_ctl(); e.s_inc = 0; e.pop = 1; e.s_stack = 1; add(6'b101000, 0, e);
    e = nop_ctl(); e.push = 1; add(6'b101001, 0, e);
    e = nop_ctl(); e.we3 = 1; e.s_inm = 2'b11; e.s_in = 2'b10; add(6'b101010, 0, e);
    e = nop_ctl(); e.we_out = 1; add(6'b101011, 0, e);
    e = nop_ctl(); e.we_out = 1; e.s_out = 2'b01; add(6'b101100, 0, e);
    e = nop_ctl(); e.we4 = 1; add(6'b111001, 0, e);
    e = nop_ctl(); e.we4 = 1; e.s_mem = 1; add(6'b110000, 0, e);
    e = nop_ctl(); e.we3 = 1; e.s_inm = 2'b10; add(6'b111110, 0, e);
    e = nop_ctl(); e.timer_e = 1; add(6'b101111, 0, e);
    e = nop_ctl(); add(6'b110111, 0, e);
    e = nop_ctl(); add(6'b101101, 1, e);

    do_reset(2'b00);

    foreach (tbl[i]) begin
      step(tbl[i].op, tbl[i].z, 2'b00);
      check($sformatf("tbl%0d", i), 32'(cur), 32'(tbl[i].want));
    end

    // EI with an edge already pending: entry lands on the instruction after EI
    step(NOP, 0, 2'b01);
    step(NOP, 0, 2'b00);
    step(EI, 0, 2'b00);
    check("ei_no_entry", 32'(cur.s_vec), 32'd0);
    step(NOP, 0, 2'b00);
    check("ei_entry", {cur.push, cur.s_ret_cur, cur.s_vec, cur.s_inc}, 4'b1110);
    check("ei_idx", {cur.vec_idx, cur.irq_ack}, 3'b0_01);
    step(NOP, 0, 2'b00);
    check("ei_isr", {cur.in_isr, cur.ie}, 2'b10);

    // simultaneous edges on both lines: idx 0 first, idx 1 right after RETI
    step(RETI, 0, 2'b00);
    step(NOP, 0, 2'b11);
    check("both_no_entry", 32'(cur.s_vec), 32'd0);
    step(NOP, 0, 2'b11);
    check("both_first", {cur.s_vec, cur.vec_idx, cur.irq_ack}, 4'b1_0_01);
    step(NOP, 0, 2'b00);
    step(RETI, 0, 2'b00);
    check("reti_ctl", {cur.s_inc, cur.pop, cur.s_stack, cur.in_isr}, 4'b0111);
    step(NOP, 0, 2'b00);
    check("both_second", {cur.s_vec, cur.vec_idx, cur.irq_ack}, 4'b1_1_10);

    // edge during ISR is held, even across EI, until RETI
    step(RETI, 0, 2'b00);
    step(NOP, 0, 2'b01);
    step(NOP, 0, 2'b00);
    check("isr2_entry", {cur.s_vec, cur.vec_idx}, 2'b1_0);
    step(NOP, 0, 2'b10);
    step(EI, 0, 2'b00);
    step(NOP, 0, 2'b00);
    check("nest_blocked", {cur.s_vec, cur.in_isr, cur.ie}, 3'b011);
    step(RETI, 0, 2'b00);
    check("nest_reti", 32'(cur.s_vec), 32'd0);
    step(NOP, 0, 2'b00);
    check("nest_after", {cur.s_vec, cur.vec_idx, cur.irq_ack}, 4'b1_1_10);

    // reset during ISR abandons the held pending request
    step(NOP, 0, 2'b10);
    do_reset(2'b00);
    check("rst_isr", {got.in_isr, got.ie, got.irq_ack, got.s_vec}, 5'b0);
    step(EI, 0, 2'b00);
    step(NOP, 0, 2'b00);
    check("rst_lost", {cur.s_vec, cur.ie}, 2'b01);

    // line held high across reset release is ignored until it re-rises
    do_reset(2'b01);
    step(EI, 0, 2'b01);
    step(NOP, 0, 2'b01);
    check("held_no_entry", {cur.s_vec, cur.ie}, 2'b01);
    step(NOP, 0, 2'b01);
    step(NOP, 0, 2'b00);
    step(NOP, 0, 2'b01);
    check("rerise_cycle", 32'(cur.s_vec), 32'd0);
    step(NOP, 0, 2'b01);
    check("rerise_entry", {cur.s_vec, cur.vec_idx, cur.irq_ack}, 4'b1_0_01);

    // random run against the model
    for (int n = 0; n < 400; n++) begin
      logic [5:0] op;
      logic [1:0] ir;
      case ($urandom_range(0, 3))
        0: op = EI;
        1: op = RETI;
        default: op = 6'($urandom_range(0, 63));
      endcase
      ir = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : irq;
      step(op, 1'($urandom_range(0, 1)), ir);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
